// File: rtl/bcd_calc_core_pkg.sv
// -----------------------------------------------------------------------------
// bcd_calc_core_pkg
// Shared definitions for the two-digit BCD calculator core:
//   - operator key codes (KEY_ADD, KEY_SUBTRACT, KEY_MULTIPLY, KEY_ENTER,
//     KEY_DIVIDE)
//   - FSM state encoding (IDLE, LOAD, EXEC, CONV, DONE)
//   - start-to-done latency constants (16 for ADD/SUB, 22 for MUL/DIV)
//   - helpers: BCD digit pair -> binary, one double-dabble iteration
// No ports (package).
// -----------------------------------------------------------------------------
package bcd_calc_core_pkg;

    localparam logic [3:0] KEY_ADD      = 4'hA;
    localparam logic [3:0] KEY_SUBTRACT = 4'hB;
    localparam logic [3:0] KEY_MULTIPLY = 4'hC;
    localparam logic [3:0] KEY_DIVIDE   = 4'hD;
    localparam logic [3:0] KEY_ENTER    = 4'hE;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        EXEC = 3'd2,
        CONV = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam int LAT_ADD_SUB = 16;
    localparam int LAT_MUL_DIV = 22;

    localparam int BIN_W      = 14;  // widest binary result: 99*99 = 9801
    localparam int BCD_W      = 16;  // four BCD digits
    localparam int CONV_STEPS = 14;  // one double-dabble shift per binary bit
    localparam int EXEC_STEPS = 7;   // one iteration per operand bit

    // Tens/ones BCD pair to binary. Only meaningful for digits 0..9.
    function automatic logic [6:0] bcd_pair_to_bin(input logic [3:0] tens,
                                                   input logic [3:0] ones);
        return 7'(7'(tens) * 7'd10 + 7'(ones));
    endfunction

    // One double-dabble iteration on {bcd[15:0], bin[13:0]}: add 3 to every
    // BCD nibble that is 5 or more, then shift the whole register left by one.
    function automatic logic [BCD_W+BIN_W-1:0] dabble_step(
        input logic [BCD_W+BIN_W-1:0] sr);
        logic [BCD_W+BIN_W-1:0] t;
        t = sr;
        for (int i = 0; i < 4; i++) begin
            if (t[BIN_W + 4*i +: 4] >= 4'd5) begin
                t[BIN_W + 4*i +: 4] = t[BIN_W + 4*i +: 4] + 4'd3;
            end
        end
        return {t[BCD_W+BIN_W-2:0], 1'b0};
    endfunction

endpackage

// File: rtl/bcd_calc_core_bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
// Sequential 14-bit double-dabble binary-to-BCD converter, one shift per edge,
// 14 shifts per run.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        load bin and run (ignored while a run is in progress)
//   bin[13:0]    binary value, sampled on the start edge
//   done         high in the cycle whose closing edge performs the last shift
//   bcd[15:0]    converted value, valid while done is high
// The load edge also performs the first shift (the BCD field is still zero,
// so no correction is needed on that step). This lets the owner capture the
// finished value on the same edge as the 14th shift, using the combinational
// next-state of the shift register presented on bcd.
// -----------------------------------------------------------------------------
module bin2bcd_seq
    import bcd_calc_core_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             done,
    output logic [BCD_W-1:0] bcd
);

    logic [BCD_W+BIN_W-1:0] sr;
    logic [BCD_W+BIN_W-1:0] sr_next;
    logic [3:0]             cnt;
    logic                   running;

    always_comb begin
        sr_next = dabble_step(running ? sr : {{BCD_W{1'b0}}, bin});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr      <= '0;
            cnt     <= '0;
            running <= 1'b0;
        end else if (running) begin
            sr  <= sr_next;
            cnt <= cnt + 4'd1;
            if (cnt == 4'(CONV_STEPS - 1)) begin
                running <= 1'b0;
            end
        end else if (start) begin
            sr      <= sr_next;
            cnt     <= 4'd1;
            running <= 1'b1;
        end
    end

    assign done = running && (cnt == 4'(CONV_STEPS - 1));
    assign bcd  = sr_next[BCD_W+BIN_W-1:BIN_W];

endmodule

// File: rtl/bcd_calc_core.sv
// -----------------------------------------------------------------------------
// bcd_calc_core
// Two-digit BCD calculator: A = digit3*10+digit2, B = digit1*10+digit0,
// op selects ADD, SUBTRACT (|A-B| with sign), MULTIPLY (7-step shift-add)
// and, when CALC_DIV_EN is defined, DIVIDE (7-step restoring, floor(A/B)).
// Without CALC_DIV_EN, KEY_DIVIDE is an unsupported op and reports err.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   digit3..digit0, op, start   request (sampled when start=1 in IDLE)
//   result3..result0            registered BCD result, result3 is the MSD
//   neg, err                    result sign (SUB only), invalid request flag
//   busy, done                  busy in LOAD/EXEC/CONV, done one cycle in DONE
//   state_dbg                   current FSM state for observation
// Handshake: start is a one-cycle request accepted only in IDLE (ignored
// elsewhere); every accepted start yields exactly one done pulse, busy is
// low during that pulse, and the next start may be given in the cycle after.
// Results, neg and err change only on the edge that enters DONE.
// -----------------------------------------------------------------------------
module bcd_calc_core
    import bcd_calc_core_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] digit3,
    input  logic [3:0] digit2,
    input  logic [3:0] digit1,
    input  logic [3:0] digit0,
    input  logic [3:0] op,
    input  logic       start,
    output logic [3:0] result3,
    output logic [3:0] result2,
    output logic [3:0] result1,
    output logic [3:0] result0,
    output logic       neg,
    output logic       err,
    output logic       busy,
    output logic       done,
    output logic [2:0] state_dbg
);

    state_t             state, state_next;
    logic [3:0]         lat_d3, lat_d2, lat_d1, lat_d0, lat_op;
    logic [6:0]         a_conv, b_conv, a_bin, b_bin;
    logic [BIN_W-1:0]   acc, exec_value, mul_term;
    logic [2:0]         step_cnt;
    logic               neg_pend, neg_r, err_r;
    logic [BCD_W-1:0]   res_bcd, conv_bcd;
    logic               op_valid, exec_last, conv_start, conv_done;
`ifdef CALC_DIV_EN
    logic [6:0]         rem, rem_next;
    logic [7:0]         trial;
    logic               div_ge;
`endif

    // Datapath combinational logic
    always_comb begin
        a_conv   = bcd_pair_to_bin(lat_d3, lat_d2);
        b_conv   = bcd_pair_to_bin(lat_d1, lat_d0);

        op_valid = (lat_op == KEY_ADD) || (lat_op == KEY_SUBTRACT) ||
                   (lat_op == KEY_MULTIPLY);
`ifdef CALC_DIV_EN
        if (lat_op == KEY_DIVIDE && b_conv != 7'd0) begin
            op_valid = 1'b1;
        end
`endif
        if (lat_d3 > 4'd9 || lat_d2 > 4'd9 || lat_d1 > 4'd9 || lat_d0 > 4'd9) begin
            op_valid = 1'b0;
        end

        // Shift-add: step k adds A<<k when bit k of B is set.
        mul_term = b_bin[step_cnt] ? (14'(a_bin) << step_cnt) : '0;

`ifdef CALC_DIV_EN
        // Restoring division: the dividend shifts out of acc[6:0] MSB-first
        // while quotient bits shift in at the bottom.
        trial    = {rem, acc[6]};
        div_ge   = trial >= {1'b0, b_bin};
        rem_next = div_ge ? 7'(trial - {1'b0, b_bin}) : trial[6:0];
`endif

        exec_value = '0;
        exec_last  = 1'b1;
        case (lat_op)
            KEY_ADD:      exec_value = 14'(a_bin) + 14'(b_bin);
            KEY_SUBTRACT: exec_value = (a_bin >= b_bin) ? 14'(a_bin - b_bin)
                                                        : 14'(b_bin - a_bin);
            KEY_MULTIPLY: begin
                exec_value = acc + mul_term;
                exec_last  = (step_cnt == 3'(EXEC_STEPS - 1));
            end
`ifdef CALC_DIV_EN
            KEY_DIVIDE: begin
                exec_value = {7'd0, acc[5:0], div_ge};
                exec_last  = (step_cnt == 3'(EXEC_STEPS - 1));
            end
`endif
            default: ;
        endcase
    end

    // FSM next state. The converter is started on the edge that leaves EXEC,
    // fed directly with the final EXEC value.
    always_comb begin
        state_next = state;
        conv_start = 1'b0;
        case (state)
            IDLE: if (start) state_next = LOAD;
            LOAD: state_next = op_valid ? EXEC : DONE;
            EXEC: begin
                if (exec_last) begin
                    state_next = CONV;
                    conv_start = 1'b1;
                end
            end
            CONV: if (conv_done) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_d3   <= '0;
            lat_d2   <= '0;
            lat_d1   <= '0;
            lat_d0   <= '0;
            lat_op   <= '0;
            a_bin    <= '0;
            b_bin    <= '0;
            acc      <= '0;
            step_cnt <= '0;
            neg_pend <= 1'b0;
            res_bcd  <= '0;
            neg_r    <= 1'b0;
            err_r    <= 1'b0;
`ifdef CALC_DIV_EN
            rem      <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        lat_d3 <= digit3;
                        lat_d2 <= digit2;
                        lat_d1 <= digit1;
                        lat_d0 <= digit0;
                        lat_op <= op;
                    end
                end
                LOAD: begin
                    a_bin    <= a_conv;
                    b_bin    <= b_conv;
                    acc      <= '0;
                    step_cnt <= '0;
                    neg_pend <= 1'b0;
`ifdef CALC_DIV_EN
                    rem      <= '0;
                    if (lat_op == KEY_DIVIDE) acc <= 14'(a_conv);
`endif
                    if (!op_valid) begin
                        res_bcd <= '0;
                        neg_r   <= 1'b0;
                        err_r   <= 1'b1;
                    end
                end
                EXEC: begin
                    acc      <= exec_value;
                    step_cnt <= step_cnt + 3'd1;
                    // Strict less-than: equal operands give +0, never -0.
                    neg_pend <= (lat_op == KEY_SUBTRACT) && (a_bin < b_bin);
`ifdef CALC_DIV_EN
                    rem      <= rem_next;
`endif
                end
                CONV: begin
                    if (conv_done) begin
                        res_bcd <= conv_bcd;
                        neg_r   <= neg_pend;
                        err_r   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    bin2bcd_seq u_conv (
        .clk   (clk),
        .rst_n (rst_n),
        .start (conv_start),
        .bin   (exec_value),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    assign result3   = res_bcd[15:12];
    assign result2   = res_bcd[11:8];
    assign result1   = res_bcd[7:4];
    assign result0   = res_bcd[3:0];
    assign neg       = neg_r;
    assign err       = err_r;
    assign busy      = (state != IDLE) && (state != DONE);
    assign done      = (state == DONE);
    assign state_dbg = state;

endmodule

// File: tb/tb_bcd_calc_core.sv
// -----------------------------------------------------------------------------
// tb_bcd_calc_core
// Self-checking bench for bcd_calc_core: directed vector table, hand-written
// sequences (start during CONV, reset during MUL EXEC) and randomized requests
// checked against an arithmetic reference model. Honors CALC_DIV_EN.
// -----------------------------------------------------------------------------
module tb_bcd_calc_core;
    import bcd_calc_core_pkg::*;

    localparam int W = 18;  // {err, neg, result[15:0]}

`ifdef CALC_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] digit3 = '0, digit2 = '0, digit1 = '0, digit0 = '0, op = '0;
    logic       start = 1'b0;
    logic [3:0] result3, result2, result1, result0;
    logic       neg, err, busy, done;
    logic [2:0] state_dbg;

    always #5 clk = ~clk;

    bcd_calc_core dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .digit3    (digit3),
        .digit2    (digit2),
        .digit1    (digit1),
        .digit0    (digit0),
        .op        (op),
        .start     (start),
        .result3   (result3),
        .result2   (result2),
        .result1   (result1),
        .result0   (result0),
        .neg       (neg),
        .err       (err),
        .busy      (busy),
        .done      (done),
        .state_dbg (state_dbg)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int             checks = 0;
    int             errors = 0;
    logic [W-1:0]   exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Straight from the arithmetic rules: integer operands, integer result,
    // decimal digits by division/modulo.
    function automatic logic [W-1:0] ref_model(input logic [3:0] a1, a0, b1, b0, o,
                                               output int lat);
        int a, b, r;
        bit bad, n;
        a   = int'(a1) * 10 + int'(a0);
        b   = int'(b1) * 10 + int'(b0);
        r   = 0;
        n   = 1'b0;
        bad = (a1 > 9) || (a0 > 9) || (b1 > 9) || (b0 > 9);
        lat = LAT_ADD_SUB;
        if (o == KEY_ADD) r = a + b;
        else if (o == KEY_SUBTRACT) begin
            r = a - b;
            if (r < 0) begin
                n = 1'b1;
                r = -r;
            end
        end
        else if (o == KEY_MULTIPLY) begin
            r   = a * b;
            lat = LAT_MUL_DIV;
        end
        else if (DIV_EN && o == KEY_DIVIDE && b != 0) begin
            r   = a / b;
            lat = LAT_MUL_DIV;
        end
        else bad = 1'b1;
        if (bad) begin
            lat = 2;
            return {1'b1, 1'b0, 16'h0000};
        end
        return {1'b0, n, 4'(r / 1000 % 10), 4'(r / 100 % 10), 4'(r / 10 % 10), 4'(r % 10)};
    endfunction

    // ---------------- driver ----------------
    // Issues one request, scrambles the inputs afterwards (the DUT must have
    // latched them), and waits for done with a bounded cycle budget. lat counts
    // edges with the start-sampling edge as edge 1. intrude_at > 0 fires an
    // extra start (99*99 MUL) at that point of the wait.
    task automatic run_op(input logic [3:0] a1, a0, b1, b0, o, input int intrude_at,
                          input string name, output logic [W-1:0] got, output int lat);
        @(negedge clk);
        digit3 = a1; digit2 = a0; digit1 = b1; digit0 = b0; op = o;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        digit3 = 4'($urandom_range(0, 15));
        digit2 = 4'($urandom_range(0, 15));
        digit1 = 4'($urandom_range(0, 15));
        digit0 = 4'($urandom_range(0, 15));
        op     = 4'($urandom_range(0, 15));
        check({name, "_busy_start"}, 32'(busy), 32'd1);
        lat = 1;
        while (done !== 1'b1 && lat < 40) begin
            if (lat == intrude_at) begin
                digit3 = 4'd9; digit2 = 4'd9; digit1 = 4'd9; digit0 = 4'd9;
                op     = KEY_MULTIPLY;
                start  = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        got   = {err, neg, result3, result2, result1, result0};
        check({name, "_busy_at_done"}, 32'(busy), 32'd0);
        @(negedge clk);
        check({name, "_done_width"}, 32'(done), 32'd0);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [3:0]  a1, a0, b1, b0, o;
        logic [15:0] res;
        logic        neg;
        logic        err;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic [3:0] a1, a0, b1, b0, o,
                           input logic [15:0] res, input logic n, input logic e, input int lat);
        vec_t v;
        v.a1 = a1; v.a0 = a0; v.b1 = b1; v.b0 = b0; v.o = o;
        v.res = res; v.neg = n; v.err = e; v.lat = lat;
        vecs.push_back(v);
    endtask

    initial begin
        logic [W-1:0] got, exp;
        logic [3:0]   r1, r0, s1, s0, ro;
        int           lat, elat, extra;

        // reset state
        repeat (3) @(negedge clk);
        check("reset_outputs", 32'({result3, result2, result1, result0, neg, err, busy, done}), 32'd0);
        check("reset_state", 32'(state_dbg), 32'(IDLE));
        rst_n = 1'b1;

        add_vec(4'd1, 4'd2, 4'd3, 4'd4, KEY_ADD,      16'h0046, 1'b0, 1'b0, 16);
        add_vec(4'd2, 4'd5, 4'd7, 4'd3, KEY_SUBTRACT, 16'h0048, 1'b1, 1'b0, 16);
        add_vec(4'd7, 4'd3, 4'd2, 4'd5, KEY_SUBTRACT, 16'h0048, 1'b0, 1'b0, 16);
        add_vec(4'd5, 4'd0, 4'd5, 4'd0, KEY_SUBTRACT, 16'h0000, 1'b0, 1'b0, 16);
        add_vec(4'd9, 4'd9, 4'd9, 4'd9, KEY_MULTIPLY, 16'h9801, 1'b0, 1'b0, 22);
        add_vec(4'd0, 4'd0, 4'd5, 4'd7, KEY_MULTIPLY, 16'h0000, 1'b0, 1'b0, 22);
        add_vec(4'hA, 4'd1, 4'd2, 4'd3, KEY_ADD,      16'h0000, 1'b0, 1'b1, 2);
        add_vec(4'd9, 4'd9, 4'd9, 4'd9, KEY_ADD,      16'h0198, 1'b0, 1'b0, 16);
        add_vec(4'd0, 4'd0, 4'd0, 4'd1, KEY_SUBTRACT, 16'h0001, 1'b1, 1'b0, 16);
        add_vec(4'd8, 4'd7, 4'd6, 4'd5, KEY_MULTIPLY, 16'h5655, 1'b0, 1'b0, 22);
        add_vec(4'd1, 4'd2, 4'd3, 4'd4, KEY_ENTER,    16'h0000, 1'b0, 1'b1, 2);
        add_vec(4'd4, 4'd2, 4'd0, 4'hF, KEY_MULTIPLY, 16'h0000, 1'b0, 1'b1, 2);
        add_vec(4'd0, 4'd0, 4'd0, 4'd0, KEY_ADD,      16'h0000, 1'b0, 1'b0, 16);
        add_vec(4'd9, 4'd9, 4'd0, 4'd0, KEY_DIVIDE,   16'h0000, 1'b0, 1'b1, 2);
        if (DIV_EN) begin
            add_vec(4'd9, 4'd9, 4'd0, 4'd7, KEY_DIVIDE, 16'h0014, 1'b0, 1'b0, 22);
            add_vec(4'd1, 4'd5, 4'd0, 4'd4, KEY_DIVIDE, 16'h0003, 1'b0, 1'b0, 22);
        end else begin
            add_vec(4'd9, 4'd9, 4'd0, 4'd7, KEY_DIVIDE, 16'h0000, 1'b0, 1'b1, 2);
        end

        foreach (vecs[i]) begin
            exp_q.push_back({vecs[i].err, vecs[i].neg, vecs[i].res});
            run_op(vecs[i].a1, vecs[i].a0, vecs[i].b1, vecs[i].b0, vecs[i].o, 0,
                   $sformatf("vec%0d", i), got, lat);
            exp = exp_q.pop_front();
            check($sformatf("vec%0d_result", i), 32'(got), 32'(exp));
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
        end

        // second start while converting: ignored, one done, first result kept
        run_op(4'd1, 4'd2, 4'd3, 4'd4, KEY_ADD, 8, "intrude", got, lat);
        check("intrude_result", 32'(got), 32'h0046);
        check("intrude_latency", 32'(lat), 32'd16);
        extra = 0;
        repeat (30) begin
            @(negedge clk);
            if (done === 1'b1) extra++;
        end
        check("intrude_extra_done", 32'(extra), 32'd0);
        check("intrude_hold", 32'({err, neg, result3, result2, result1, result0}), 32'h0046);

        // reset in the 4th EXEC cycle of a multiply
        run_op(4'd9, 4'd9, 4'd9, 4'd9, KEY_ADD, 0, "pre_reset", got, lat);
        check("pre_reset_result", 32'(got), 32'h0198);
        @(negedge clk);
        digit3 = 4'd9; digit2 = 4'd9; digit1 = 4'd9; digit0 = 4'd9; op = KEY_MULTIPLY;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_mul_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_reset_outputs", 32'({result3, result2, result1, result0, neg, err, busy, done}), 32'd0);
        check("mid_reset_state", 32'(state_dbg), 32'(IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        run_op(4'd1, 4'd2, 4'd3, 4'd4, KEY_ADD, 0, "post_reset", got, lat);
        check("post_reset_result", 32'(got), 32'h0046);
        check("post_reset_latency", 32'(lat), 32'd16);

        // randomized requests against the model
        for (int n = 0; n < 40; n++) begin
            r1 = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            r0 = 4'($urandom_range(0, 9));
            s1 = 4'($urandom_range(0, 9));
            s0 = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            case ($urandom_range(0, 5))
                0: ro = KEY_ADD;
                1: ro = KEY_SUBTRACT;
                2: ro = KEY_MULTIPLY;
                3: ro = KEY_DIVIDE;
                4: ro = KEY_ENTER;
                default: ro = 4'($urandom_range(0, 15));
            endcase
            exp_q.push_back(ref_model(r1, r0, s1, s0, ro, elat));
            run_op(r1, r0, s1, s0, ro, 0, $sformatf("rnd%0d", n), got, lat);
            exp = exp_q.pop_front();
            check($sformatf("rnd%0d_result", n), 32'(got), 32'(exp));
            check($sformatf("rnd%0d_latency", n), 32'(lat), 32'(elat));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
